serial_stream_adder: RTL and testbench

SERIAL_STREAM_ADDER -- requirements
Module: serial_stream_adder

---
 rtl/serial_stream_adder.sv | 96 +++++++++
 tb/tb_serial_stream_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_stream_adder.sv
// Bit-serial adder/subtractor: N operand bit pairs arrive LSB first under bit_valid.
// The parallel result is held with valid/ready until the consumer accepts it.
module serial_stream_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         bit_valid,
    input  logic         a_bit,
    input  logic         b_bit,
    input  logic         out_ready,
    output logic         busy,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t        state;
    logic          sub_q;
    logic          carry;
    logic [CW-1:0] cnt;

    logic b_eff;
    logic s_bit;
    logic c_next;
    logic last_bit;

    // Subtraction is A + ~B + 1: B is inverted per bit and the carry is preloaded with sub.
    always_comb begin
        b_eff    = b_bit ^ sub_q;
        s_bit    = a_bit ^ b_eff ^ carry;
        c_next   = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
        last_bit = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sub_q     <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sub_q <= sub;
                        carry <= sub;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (bit_valid) begin
                        carry <= c_next;
                        sum   <= {s_bit, sum[N-1:1]};
                        cnt   <= cnt + CW'(1);
                        if (last_bit) begin
                            // carry still holds the carry into the MSB here
                            cout      <= c_next;
                            ovf       <= carry ^ c_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_stream_adder.sv
// Directed and randomized frames for serial_stream_adder, checked against an
// integer-arithmetic reference of the add/subtract result.
module tb_serial_stream_adder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    serial_stream_adder #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .bit_valid(bit_valid),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .out_ready(out_ready),
        .busy     (busy),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic op);
        int ua, ub, raw, sa, sb, r;
        logic [N-1:0] s;
        ua  = int'(a);
        ub  = int'(b);
        raw = op ? ua + ((1 << N) - 1 - ub) + 1 : ua + ub;
        s   = raw[N-1:0];
        sa  = ua - (a[N-1] ? (1 << N) : 0);
        sb  = ub - (b[N-1] ? (1 << N) : 0);
        r   = op ? sa - sb : sa + sb;
        return {raw >= (1 << N), (r < -(1 << (N - 1))) || (r >= (1 << (N - 1))), s};
    endfunction

    task automatic run_frame(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic op, input int stall_at, input int stall_len,
                             input int done_hold, input bit noise);
        logic [N+1:0] exp;
        exp = model(a, b, op);
        @(negedge clk);
        if (noise) begin
            for (int k = 0; k < 2; k++) begin
                bit_valid = 1'b1;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                out_ready = 1'b1;
                @(negedge clk);
            end
            out_ready = 1'b0;
        end
        start     = 1'b1;
        sub       = op;
        bit_valid = 1'b1;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        check({tag, "_busy_start"}, 32'(busy), 32'(1));
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    bit_valid = 1'b0;
                    a_bit     = 1'($urandom);
                    b_bit     = 1'($urandom);
                    start     = k[0];
                    out_ready = ~k[0];
                    @(negedge clk);
                end
                start     = 1'b0;
                out_ready = 1'b0;
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            @(negedge clk);
            if (i == N - 2)
                check({tag, "_valid_early"}, 32'(out_valid), 32'(0));
        end
        bit_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_sum"}, 32'(sum), 32'(exp[N-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[N+1]));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp[N]));
        for (int k = 0; k < done_hold; k++) begin
            out_ready = 1'b0;
            if (noise) begin
                bit_valid = 1'b1;
                start     = 1'b1;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
            check({tag, "_hold_res"}, 32'({cout, ovf, sum}), 32'({exp[N+1], exp[N], exp[N-1:0]}));
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, 32'(out_valid), 32'(0));
        check({tag, "_busy_fall"}, 32'(busy), 32'(0));
        check({tag, "_retain"}, 32'({cout, ovf, sum}), 32'({exp[N+1], exp[N], exp[N-1:0]}));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_flags", 32'({cout, ovf, out_valid, busy}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        run_frame("add_5_3", 4'b0101, 4'b0011, 1'b0, N, 0, 0, 1'b0);
        run_frame("add_f_1", 4'b1111, 4'b0001, 1'b0, N, 0, 0, 1'b0);

        // abort a frame after two accepted bits
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b0;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_flags", 32'({cout, ovf, out_valid, busy}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        run_frame("post_rst", 4'b0110, 4'b0001, 1'b0, N, 0, 0, 1'b0);

        run_frame("sub_3_5", 4'b0011, 4'b0101, 1'b1, N, 0, 0, 1'b0);
        run_frame("sub_5_3", 4'b0101, 4'b0011, 1'b1, N, 0, 0, 1'b0);
        run_frame("stall", 4'b0101, 4'b0011, 1'b0, 2, 3, 0, 1'b1);
        run_frame("done_hold", 4'b1001, 4'b0111, 1'b1, N, 0, 5, 1'b1);

        for (int f = 0; f < 40; f++) begin
            run_frame("rand", N'($urandom), N'($urandom), 1'($urandom),
                      int'($urandom_range(0, N)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
